// File: rtl/mmcm_drp_sequencer.sv
// Reconfigures an MMCME2_ADV over DRP: holds the MMCM in reset, applies a stream of
// masked read-modify-write updates, then releases reset and waits for a synchronised LOCKED.
module mmcm_drp_sequencer #(
    parameter int RST_HOLD     = 8,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65536
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [6:0]  cmd_addr,
    input  logic [15:0] cmd_mask,
    input  logic [15:0] cmd_data,
    input  logic        cmd_last,
    output logic [6:0]  daddr,
    output logic        den,
    output logic        dwe,
    output logic [15:0] di,
    input  logic [15:0] drp_do,
    input  logic        drdy,
    input  logic        locked,
    output logic        mmcm_rst,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);
    localparam int MAX_A   = (RST_HOLD > DRDY_TIMEOUT) ? RST_HOLD : DRDY_TIMEOUT;
    localparam int MAX_CNT = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] DRDY_END = CNT_W'(DRDY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_END = CNT_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, HOLD_RST, GET_CMD, READ, WAIT_RD, WRITE, WAIT_WR, RELEASE, WAIT_LOCK, FAIL
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      mask_q, data_q;
    logic             last_q;
    logic             lock_meta_q, lock_s_q;
    logic             cmd_ready_q, den_q, dwe_q, mmcm_rst_q, busy_q, done_q, err_q;
    logic [6:0]       daddr_q;
    logic [15:0]      di_q;
    logic [1:0]       err_code_q;
    logic [15:0]      di_d;

    assign di_d = (drp_do & mask_q) | data_q;

    // LOCKED comes from the MMCM output domain, so it is resynchronised onto DCLK.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= locked;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mask_q     <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            cmd_ready_q <= 1'b0;
            den_q      <= 1'b0;
            dwe_q      <= 1'b0;
            daddr_q    <= '0;
            di_q       <= '0;
            mmcm_rst_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            den_q  <= 1'b0;
            dwe_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                IDLE: if (cmd_valid) begin
                    state_q    <= HOLD_RST;
                    mmcm_rst_q <= 1'b1;
                    busy_q     <= 1'b1;
                    err_code_q <= 2'd0;
                    cnt_q      <= '0;
                end
                HOLD_RST: if (cnt_q == HOLD_END) begin
                    state_q     <= GET_CMD;
                    cmd_ready_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                GET_CMD: if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_q <= 1'b0;
                    daddr_q     <= cmd_addr;
                    mask_q      <= cmd_mask;
                    data_q      <= cmd_data;
                    last_q      <= cmd_last;
                    den_q       <= 1'b1;
                    state_q     <= READ;
                end
                READ: begin
                    state_q <= WAIT_RD;
                    cnt_q   <= '0;
                end
                WAIT_RD: if (drdy) begin
                    di_q    <= di_d;
                    den_q   <= 1'b1;
                    dwe_q   <= 1'b1;
                    state_q <= WRITE;
                end else if (cnt_q == DRDY_END) begin
                    state_q    <= FAIL;
                    err_q      <= 1'b1;
                    err_code_q <= 2'd1;
                    mmcm_rst_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                WRITE: begin
                    state_q <= WAIT_WR;
                    cnt_q   <= '0;
                end
                WAIT_WR: if (drdy) begin
                    if (last_q) begin
                        state_q    <= RELEASE;
                        mmcm_rst_q <= 1'b0;
                    end else begin
                        state_q     <= GET_CMD;
                        cmd_ready_q <= 1'b1;
                    end
                end else if (cnt_q == DRDY_END) begin
                    state_q    <= FAIL;
                    err_q      <= 1'b1;
                    err_code_q <= 2'd1;
                    mmcm_rst_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                RELEASE: begin
                    state_q <= WAIT_LOCK;
                    cnt_q   <= '0;
                end
                WAIT_LOCK: if (lock_s_q) begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end else if (cnt_q == LOCK_END) begin
                    state_q    <= FAIL;
                    err_q      <= 1'b1;
                    err_code_q <= 2'd2;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                // The unread remainder of the stream is left for the host to drain.
                FAIL: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign daddr     = daddr_q;
    assign den       = den_q;
    assign dwe       = dwe_q;
    assign di        = di_q;
    assign mmcm_rst  = mmcm_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// Bench for mmcm_drp_sequencer: behavioural DRP register file and MMCM lock model,
// expected DRP transaction list derived from the update entries.
module tb_mmcm_drp_sequencer;
    localparam int RST_HOLD = 8;
    localparam int DRDY_TO  = 64;
    localparam int LOCK_TO  = 200;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [6:0]  cmd_addr = '0;
    logic [15:0] cmd_mask = '0;
    logic [15:0] cmd_data = '0;
    logic        cmd_last = 1'b0;
    logic [6:0]  daddr;
    logic        den, dwe;
    logic [15:0] di;
    logic [15:0] drp_do = '0;
    logic        drdy = 1'b0;
    logic        locked = 1'b0;
    logic        mmcm_rst, busy, done, err;
    logic [1:0]  err_code;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mmcm_drp_sequencer #(
        .RST_HOLD(RST_HOLD), .DRDY_TIMEOUT(DRDY_TO), .LOCK_TIMEOUT(LOCK_TO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_mask(cmd_mask), .cmd_data(cmd_data), .cmd_last(cmd_last),
        .daddr(daddr), .den(den), .dwe(dwe), .di(di), .drp_do(drp_do), .drdy(drdy),
        .locked(locked), .mmcm_rst(mmcm_rst), .busy(busy), .done(done), .err(err),
        .err_code(err_code)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [6:0]  a;
        logic [15:0] m;
        logic [15:0] d;
    } ent_t;
    ent_t ents[$];

    // DRP register file, MMCM lock behaviour and event monitors
    logic [15:0] mem [128];
    logic [15:0] ref_mem [128];
    int   lat_min = 1, lat_max = 1, hang_acc = -1, acc_no = 0, pend = 0;
    bit   early = 1'b0;
    logic [15:0] pend_rd = '0;
    logic [6:0]  log_a[$];
    bit          log_w[$];
    logic [15:0] log_d[$];
    bit   lock_en = 1'b1;
    int   lock_dly = 20, lock_cnt = 0;
    int   cyc = 0, done_cnt = 0, err_cnt = 0, rise_cnt = 0;
    int   first_den_cyc = -1, rst_rise_cyc = -1, rst_fall_cyc = -1, err_cyc = -1, hang_den_cyc = -1;
    logic rst_prev = 1'b0, err_rst = 1'b0;
    logic [1:0] code_at_start = 2'd0;

    always @(negedge clk) begin
        cyc++;
        drdy = 1'b0;
        drp_do = 16'($urandom);
        if (!reset_n) pend = 0;
        else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                drdy = 1'b1;
                drp_do = pend_rd;
            end
        end
        if (reset_n && den) begin
            chk("rst_held_during_access", 32'(mmcm_rst), 32'd1);
            chk("one_outstanding", pend, 0);
            if (first_den_cyc < 0) first_den_cyc = cyc;
            log_a.push_back(daddr);
            log_w.push_back(dwe);
            log_d.push_back(dwe ? di : 16'h0);
            pend_rd = mem[daddr];
            if (dwe) mem[daddr] = di;
            if (acc_no == hang_acc) hang_den_cyc = cyc;
            else if (early) begin
                drdy = 1'b1;
                drp_do = 16'hDEAD;
                pend = 1;
            end else pend = $urandom_range(lat_max, lat_min);
            acc_no++;
        end
        if (cmd_ready) chk("ready_only_in_get_cmd", 32'({mmcm_rst, den}), 32'b10);
        if (dwe) chk("dwe_with_den", 32'(den), 32'd1);
        if (mmcm_rst || !lock_en) begin
            lock_cnt = 0;
            locked = 1'b0;
        end else if (lock_cnt < lock_dly) lock_cnt++;
        else locked = 1'b1;
        if (mmcm_rst && !rst_prev) begin
            rst_rise_cyc = cyc;
            rise_cnt++;
            code_at_start = err_code;
        end
        if (!mmcm_rst && rst_prev) rst_fall_cyc = cyc;
        rst_prev = mmcm_rst;
        if (done) done_cnt++;
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
            err_rst = mmcm_rst;
        end
    end

    function automatic ent_t rand_ent();
        ent_t e;
        e.a = 7'($urandom);
        e.m = 16'($urandom);
        e.d = 16'($urandom) & ~e.m;
        return e;
    endfunction

    task automatic run_seq(input int gap, output bit aborted);
        int t;
        aborted = 1'b0;
        log_a.delete(); log_w.delete(); log_d.delete();
        acc_no = 0; done_cnt = 0; err_cnt = 0; rise_cnt = 0; first_den_cyc = -1;
        for (int k = 0; k < 128; k++) ref_mem[k] = mem[k];
        for (int i = 0; i < ents.size(); i++) begin
            if (err_cnt != 0) begin aborted = 1'b1; break; end
            cmd_addr = ents[i].a; cmd_mask = ents[i].m; cmd_data = ents[i].d;
            cmd_last = (i == ents.size() - 1);
            cmd_valid = 1'b1;
            t = 0;
            do begin @(negedge clk); t++; end while (!cmd_ready && err_cnt == 0 && t < 3000);
            if (err_cnt != 0) begin aborted = 1'b1; cmd_valid = 1'b0; break; end
            if (!cmd_ready) begin
                chk("accept_timeout", 32'd0, 32'd1);
                aborted = 1'b1; cmd_valid = 1'b0; break;
            end
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            if (i < ents.size() - 1) begin repeat (gap) @(posedge clk); #1; end
        end
        t = 0;
        while (done_cnt == 0 && err_cnt == 0 && t < 3000) begin @(negedge clk); t++; end
        if (done_cnt == 0 && err_cnt == 0) chk("sequence_end_timeout", 32'd0, 32'd1);
        repeat (3) @(posedge clk); #1;
    endtask

    // Expected DRP traffic: per entry a read, then a write of (old & mask) | data.
    task automatic check_log(input string tag, input int max_ops);
        logic [6:0]  ea[$];
        bit          ew[$];
        logic [15:0] ed[$];
        logic [15:0] m [128];
        for (int k = 0; k < 128; k++) m[k] = ref_mem[k];
        foreach (ents[i]) begin
            ea.push_back(ents[i].a); ew.push_back(1'b0); ed.push_back(16'h0);
            m[ents[i].a] = (m[ents[i].a] & ents[i].m) | ents[i].d;
            ea.push_back(ents[i].a); ew.push_back(1'b1); ed.push_back(m[ents[i].a]);
        end
        while (ea.size() > max_ops) begin
            void'(ea.pop_back()); void'(ew.pop_back()); void'(ed.pop_back());
        end
        chk({tag, "_num_accesses"}, log_a.size(), ea.size());
        for (int i = 0; i < ea.size() && i < log_a.size(); i++) begin
            chk({tag, "_addr"}, 32'(log_a[i]), 32'(ea[i]));
            chk({tag, "_is_write"}, 32'(log_w[i]), 32'(ew[i]));
            if (ew[i]) chk({tag, "_di"}, 32'(log_d[i]), 32'(ed[i]));
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got time limit, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit   ab;
        int   t;
        ent_t e;
        for (int k = 0; k < 128; k++) mem[k] = 16'($urandom);

        repeat (3) @(posedge clk); #1;
        chk("reset_outputs", 32'({cmd_ready, den, dwe, mmcm_rst, busy, done, err, err_code, daddr, di}), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("idle_after_reset", 32'({busy, mmcm_rst, cmd_ready}), 32'd0);

        // single entry, known register value
        mem[8] = 16'hFFFF;
        ents.delete();
        ents.push_back('{7'h08, 16'h1000, 16'h0041});
        lat_min = 1; lat_max = 1; lock_dly = 20;
        run_seq(0, ab);
        check_log("t1", 1000);
        chk("t1_reg_value", 32'(mem[8]), 32'h1041);
        chk("t1_done_count", done_cnt, 1);
        chk("t1_err_count", err_cnt, 0);
        chk("t1_err_code", 32'(err_code), 32'd0);
        chk("t1_rst_hold_ge", 32'((first_den_cyc - rst_rise_cyc) >= RST_HOLD), 32'd1);
        chk("t1_busy_after", 32'({busy, mmcm_rst}), 32'd0);

        // three entries with gaps
        ents.delete();
        e = rand_ent(); e.a = 7'h08; ents.push_back(e);
        e = rand_ent(); e.a = 7'h09; ents.push_back(e);
        e = rand_ent(); e.a = 7'h14; ents.push_back(e);
        lat_min = 1; lat_max = 3;
        run_seq(5, ab);
        check_log("t2", 1000);
        chk("t2_single_rst_window", rise_cnt, 1);
        chk("t2_done_count", done_cnt, 1);

        // second read never answered
        ents.delete();
        for (int i = 0; i < 3; i++) ents.push_back(rand_ent());
        hang_acc = 2;
        run_seq(2, ab);
        chk("t3_aborted", 32'(ab), 32'd1);
        check_log("t3", 3);
        chk("t3_err_count", err_cnt, 1);
        chk("t3_done_count", done_cnt, 0);
        chk("t3_err_latency", err_cyc - hang_den_cyc, DRDY_TO + 1);
        chk("t3_rst_at_err", 32'(err_rst), 32'd0);
        chk("t3_err_code", 32'(err_code), 32'd1);
        chk("t3_idle_after", 32'({busy, mmcm_rst}), 32'd0);
        hang_acc = -1;

        // lock never arrives, then a clean retry
        ents.delete();
        ents.push_back(rand_ent());
        lock_en = 1'b0;
        run_seq(0, ab);
        chk("t4_err_count", err_cnt, 1);
        chk("t4_err_code", 32'(err_code), 32'd2);
        chk("t4_lock_latency", err_cyc - rst_fall_cyc, LOCK_TO + 1);
        repeat (5) @(posedge clk); #1;
        chk("t4_err_code_held", 32'(err_code), 32'd2);
        lock_en = 1'b1;
        ents.delete();
        for (int i = 0; i < 2; i++) ents.push_back(rand_ent());
        run_seq(1, ab);
        check_log("t4b", 1000);
        chk("t4b_code_cleared_at_start", 32'(code_at_start), 32'd0);
        chk("t4b_done_count", done_cnt, 1);
        chk("t4b_err_code", 32'(err_code), 32'd0);

        // async reset while waiting for a write acknowledge
        lat_min = 10; lat_max = 10;
        e = rand_ent();
        cmd_addr = e.a; cmd_mask = e.m; cmd_data = e.d; cmd_last = 1'b1; cmd_valid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!cmd_ready && t < 200);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!(den && dwe) && t < 200);
        chk("t5_write_issued", 32'(den && dwe), 32'd1);
        @(negedge clk);
        chk("t5_busy_before_reset", 32'({busy, mmcm_rst}), 32'b11);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_async_clear", 32'({cmd_ready, den, dwe, mmcm_rst, busy, done, err, err_code, daddr, di}), 32'd0);
        @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("t5_idle_after_release", 32'({busy, cmd_ready, mmcm_rst, den}), 32'd0);
        lat_min = 1; lat_max = 3;
        ents.delete();
        for (int i = 0; i < 2; i++) ents.push_back(rand_ent());
        run_seq(0, ab);
        check_log("t5", 1000);
        chk("t5_done_count", done_cnt, 1);

        // drdy on the den cycle carries junk; the following one carries real data
        early = 1'b1;
        ents.delete();
        for (int i = 0; i < 3; i++) ents.push_back(rand_ent());
        run_seq(0, ab);
        check_log("t6", 1000);
        chk("t6_done_count", done_cnt, 1);
        early = 1'b0;

        for (int r = 0; r < 5; r++) begin
            int n;
            n = $urandom_range(4, 1);
            ents.delete();
            for (int i = 0; i < n; i++) ents.push_back(rand_ent());
            lat_min = 1; lat_max = $urandom_range(5, 1);
            early = 1'($urandom_range(1, 0));
            lock_dly = $urandom_range(30, 0);
            run_seq($urandom_range(3, 0), ab);
            check_log($sformatf("rnd%0d", r), 1000);
            chk($sformatf("rnd%0d_done", r), done_cnt, 1);
            chk($sformatf("rnd%0d_err_code", r), 32'(err_code), 32'd0);
        end
        early = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
